// File: rtl/seq_1101_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_1101_tx_if
//  Brief    : Payload word handshake (valid/ready) into the 1101 transmitter
//  Revision : 1.0  initial release
// ============================================================================
interface seq_1101_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  // Word producer side
  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  // Transmitter side
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/seq_1101_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_1101_tx
//  Brief    : Serial frame transmitter: sync 1101, zero-stuffed MSB-first
//             payload, trailer 00. Stuffing keeps 1101 unique per frame.
//  Revision : 1.0  initial release
// ============================================================================
module seq_1101_tx #(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_1101_tx_if.slave in_if,
  output logic         out,
  output logic         out_en,
  output logic         busy,
  output logic         frame_done
);

  localparam int         CNT_W      = $clog2(DATA_W + 1);
  localparam logic [3:0] C_SYNC_PAT = 4'b1101;

  // Each state names the kind of bit currently on the line
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_DATA  = 3'd2,
    S_STUFF = 3'd3,
    S_TRAIL = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        phase_q, phase_d;   // index within sync / trailer
  logic [CNT_W-1:0]  cnt_q,   cnt_d;     // payload bits consumed
  logic [DATA_W-1:0] shift_q, shift_d;   // payload, next bit at MSB
  logic [2:0]        hist_q,  hist_d;    // last three bits put on the line
  logic              out_q,   out_d;
  logic              payload_step;

  // State, datapath and line registers; reset clears the line at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      hist_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hist_q  <= hist_d;
      out_q   <= out_d;
    end
  end

  // Choose the next line bit; out_d is what the line shows next cycle
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    out_d        = 1'b0;
    payload_step = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_if.in_valid) begin
          state_d = S_SYNC;
          phase_d = 2'd0;
          cnt_d   = '0;
          shift_d = in_if.in_data;
          out_d   = C_SYNC_PAT[3];
        end
      end
      S_SYNC: begin
        if (phase_q == 2'd3) begin
          payload_step = 1'b1;
        end else begin
          phase_d = phase_q + 2'd1;
          out_d   = C_SYNC_PAT[2'd2 - phase_q];
        end
      end
      S_DATA, S_STUFF: begin
        payload_step = 1'b1;
      end
      S_TRAIL: begin
        if (phase_q == 2'd0) begin
          phase_d = 2'd1;
        end else begin
          state_d = S_IDLE;
          phase_d = 2'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared by the last sync bit and every payload/stuff bit: a 1 that
    // would complete 110->1 on the line is held back behind a stuffed 0.
    if (payload_step) begin
      if (cnt_q == CNT_W'(DATA_W)) begin
        state_d = S_TRAIL;
        phase_d = 2'd0;
      end else if (hist_q == 3'b110 && shift_q[DATA_W-1]) begin
        state_d = S_STUFF;
      end else begin
        state_d = S_DATA;
        out_d   = shift_q[DATA_W-1];
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    // History follows every emitted bit and is cleared between frames
    if (state_d == S_IDLE) begin
      hist_d = '0;
    end else begin
      hist_d = {hist_q[1:0], out_d};
    end
  end

  assign out            = out_q;
  assign out_en         = (state_q != S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = (state_q == S_TRAIL) && (phase_q == 2'd1);
  assign in_if.in_ready = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_1101_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_1101_tx
//  Brief    : Self-checking bench for seq_1101_tx against a frame-level model
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_1101_tx;

  localparam int DATA_W = 8;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic clk_en = 1'b0;

  logic out, out_en, busy, frame_done;

  seq_1101_tx_if #(.DATA_W(DATA_W)) bus ();

  seq_1101_tx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (bus),
    .out        (out),
    .out_en     (out_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  int checks  = 0;
  int fails   = 0;
  int started = 0;   // frames the model saw accepted
  int det_cnt = 0;   // 1101 occurrences seen on the line
  int run     = 0;   // current out_en run length

  bit exp_q[$];      // remaining expected line bits of the frame in flight
  int len_q[$];      // expected length of each frame
  bit fr_bits[0:31];
  int fr_len;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Frame as the line must carry it: sync, payload with a 0 inserted before
  // any 1 that would follow 110 on the line, then trailer.
  task automatic build(input logic [DATA_W-1:0] d);
    bit b;
    fr_len = 0;
    fr_bits[0] = 1; fr_bits[1] = 1; fr_bits[2] = 0; fr_bits[3] = 1;
    fr_len = 4;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b = d[i];
      if (b && fr_bits[fr_len-3] && fr_bits[fr_len-2] && !fr_bits[fr_len-1]) begin
        fr_bits[fr_len] = 0;
        fr_len++;
      end
      fr_bits[fr_len] = b;
      fr_len++;
    end
    fr_bits[fr_len] = 0; fr_bits[fr_len+1] = 0;
    fr_len += 2;
  endtask

  task automatic pin(input string name, input logic [DATA_W-1:0] d, input int len, input logic [31:0] bits);
    logic [31:0] v;
    build(d);
    v = '0;
    for (int i = 0; i < fr_len; i++) v = {v[30:0], fr_bits[i]};
    check({name, "_len"}, fr_len, len);
    check({name, "_bits"}, v, bits);
  endtask

  // Per-cycle compare plus model step: expected outputs for this cycle are
  // the front of the frame queue, or idle when nothing is in flight.
  initial begin
    logic [4:0] exp_vec;
    logic [3:0] sr;
    bit         cur_busy;
    bit         e;
    sr = '0;
    forever begin
      @(negedge clk);
      cur_busy = 0;
      exp_vec  = 5'b00001;
      if (!rst_n) begin
        exp_q.delete();
        len_q.delete();
        run = 0;
      end else if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        cur_busy = 1;
        exp_vec  = {e, 1'b1, 1'b1, (exp_q.size() == 0), 1'b0};
      end
      check("cycle{out,out_en,busy,done,ready}",
            {out, out_en, busy, frame_done, bus.in_ready}, exp_vec);

      sr = {sr[2:0], out};
      if (sr == 4'b1101) det_cnt++;

      if (out_en) run++;
      else if (run != 0) begin
        if (len_q.size() > 0) check("frame_len", run, len_q.pop_front());
        else check("frame_len_unexpected", run, 0);
        run = 0;
      end

      if (rst_n && !cur_busy && bus.in_valid) begin
        build(bus.in_data);
        for (int i = 0; i < fr_len; i++) exp_q.push_back(fr_bits[i]);
        len_q.push_back(fr_len);
        started++;
      end
    end
  end

  task automatic wait_started(input int target, input int budget);
    int n;
    n = 0;
    while (started < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (started < target) begin
      fails++; checks++;
      $display("FAIL accept_timeout: started %0d required %0d", started, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      fails++; checks++;
      $display("FAIL idle_timeout: %0d bits left required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic send_one(input logic [DATA_W-1:0] d);
    int tgt;
    tgt = started + 1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    wait_started(tgt, 50);
    bus.in_valid = 1'b0;
  endtask

  // Directed cases, mid-frame reset, then randomized traffic
  initial begin
    int tgt;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    pin("model_00", 8'h00, 14, 32'b11010000000000);
    pin("model_B6", 8'hB6, 16, 32'b1101100110011000);
    pin("model_FF", 8'hFF, 14, 32'b11011111111100);
    pin("model_DD", 8'hDD, 16, 32'b1101110011100100);

    #2 rst_n = 1'b0;
    #1 check("reset_async", {out, out_en, busy, frame_done, bus.in_ready}, 5'b00001);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    send_one(8'h00); wait_idle(40);
    send_one(8'hB6); wait_idle(40);
    check("det_after_directed", det_cnt, 2);

    // Back-to-back with in_valid held high across the frame boundary
    tgt = started;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    wait_started(tgt + 1, 50);
    bus.in_data  = 8'hDD;
    wait_started(tgt + 2, 50);
    bus.in_valid = 1'b0;
    wait_idle(40);
    check("det_after_b2b", det_cnt, 4);

    // Reset in the middle of the payload: line must drop immediately
    send_one(8'hAA);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("reset_midframe", {out, out_en, busy, frame_done, bus.in_ready}, 5'b00001);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_one(8'h0F); wait_idle(40);
    check("det_after_reset", det_cnt, 6);

    // Random words with random valid gaps
    tgt = started + 2000;
    n = 0;
    while (started < tgt && n < 80000) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = DATA_W'($urandom);
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("random_frames", started, tgt);
    wait_idle(40);
    check("det_total", det_cnt, started);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
